regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, register address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 1, where 1 means register 0 is hardwired to zero.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port we, input, 1, write enable.
REQ-007 SHALL have port waddr, input, ADDR_W, write address.
REQ-008 SHALL have port wdata, input, DATA_W, write data.
REQ-009 SHALL have ports raddr1 and raddr2, input, ADDR_W each, read addresses.
REQ-010 SHALL have ports rdata1 and rdata2, output, DATA_W each, read data (combinational).
REQ-011 SHALL have ports rvalid1 and rvalid2, output, 1 each; 1 means the addressed register is not reserved.
REQ-012 SHALL have port rsv_en, input, 1, reserve request, which marks a register pending a future write.
REQ-013 SHALL have port rsv_addr, input, ADDR_W, the register to reserve.
REQ-014 SHALL have port clr_req, input, 1, bulk-clear request.
REQ-015 SHALL have port busy, output, 1, which is 1 while a bulk clear is in progress.
REQ-016 SHALL have port clr_done, output, 1, a one-cycle pulse on the final clear cycle.

Function
REQ-017 SHALL write wdata into regs[waddr] on the rising clk edge when we=1 and state=IDLE.
REQ-018 SHALL ignore writes to address 0 when ZERO_REG=1; reads of address 0 SHALL then return 0 with rvalid=1.
REQ-019 SHALL bypass write data to a read port in the same cycle: if we=1, state=IDLE and waddr==raddrN (and the address is not the hardwired zero), then rdataN=wdata and rvalidN=1.
REQ-020 SHALL otherwise drive rdataN=regs[raddrN] and rvalidN=~pend[raddrN].
REQ-021 SHALL keep one pend bit per register: rsv_en=1 sets pend[rsv_addr]; an accepted write clears pend[waddr].
REQ-022 SHALL let reserve win when the same address is reserved and written in one cycle: data is written and pend is left set.
REQ-023 SHALL ignore rsv_en to address 0 when ZERO_REG=1, and SHALL ignore rsv_en while state=CLEAR.
REQ-024 SHALL implement an FSM with states IDLE and CLEAR; IDLE->CLEAR when clr_req=1; CLEAR->IDLE after the cycle with clear index == DEPTH-1.
REQ-025 SHALL, in CLEAR, zero one register per cycle and its pend bit, using an ADDR_W-bit index starting at 0 and incrementing by 1; a clear takes exactly DEPTH cycles.
REQ-026 SHALL set busy=1 exactly while state=CLEAR; clr_done=1 only in the cycle where the index equals DEPTH-1.
REQ-027 SHALL, while busy=1, ignore we, force rdataN=0 and rvalidN=0, and ignore clr_req (no restart).
REQ-028 SHALL accept clr_req and we in the same IDLE cycle: the write is performed, then the clear overwrites it.
REQ-029 SHALL not wrap the index past DEPTH-1: it returns to 0 on exit to IDLE.

Reset
REQ-030 SHALL, on rst_n=0 and asynchronously, set all registers to 0, all pend bits to 0, state to IDLE, and the clear index to 0.
REQ-031 SHALL drive these outputs during reset: busy=0, clr_done=0, rvalidN=1, rdataN=0.
REQ-032 SHALL abort a clear when reset is asserted mid-clear; after release the block SHALL be IDLE with all registers at zero.

Structure
REQ-033 SHALL place the FSM state enum (IDLE, CLEAR) in shared package regfile_pkg.
REQ-034 SHALL factor the clear FSM plus index counter into sub-module regfile_clr_ctl (ports clk, rst_n, clr_req, busy, clr_done, clr_idx).
REQ-035 SHALL contain no simulation-only delays or $display in synthesizable RTL.

Verification
REQ-036 SHALL cover basic write/read: write 0xA5 to r3, read r3 on the next cycle -> rdata1=0xA5, rvalid1=1.
REQ-037 SHALL cover bypass: we=1, waddr=5, wdata=0x3C, raddr2=5 in the same cycle -> rdata2=0x3C in that cycle.
REQ-038 SHALL cover the zero register: write 0xFF to r0 with ZERO_REG=1 -> reading r0 returns 0x00, rvalid=1.
REQ-039 SHALL cover the scoreboard: reserve r2 -> rvalid1=0 for raddr1=2; a later write of 0x11 to r2 -> rvalid1=1 and rdata1=0x11; a reserve and write to r4 in the same cycle -> r4 is written and pend stays set.
REQ-040 SHALL cover bulk clear: fill all 8 registers, pulse clr_req -> busy=1 for 8 cycles, clr_done on the 8th, we ignored during the clear, all reads 0 afterwards.
REQ-041 SHALL cover reset mid-clear: assert rst_n=0 at clear index 3 -> immediately busy=0 and all registers 0; a normal write succeeds after release.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile_pkg                                                 |
// | Purpose: Shared types for the scoreboarded register file: the bulk   |
// |          clear FSM state encoding.                                   |
// | Ports  : none (package)                                              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package regfile_pkg;

  // Bulk-clear controller states, explicit 1-bit encoding.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_clr_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile_clr_ctl                                             |
// | Purpose: Bulk-clear sequencer. On clr_req walks an index from 0 to   |
// |          2**ADDR_W-1, one register per cycle, then returns to IDLE.  |
// | Ports  : clk      - clock, rising edge                               |
// |          rst_n    - asynchronous active-low reset                    |
// |          clr_req  - start a bulk clear (ignored while busy)          |
// |          busy     - 1 while the clear is in progress                 |
// |          clr_done - 1 in the final clear cycle                       |
// |          clr_idx  - register being cleared this cycle                |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module regfile_clr_ctl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic. The index is held at 0 in IDLE and reset to 0 on
  // exit, so it never wraps past the last register.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (clr_req) state_d = CLEAR;
      end
      CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy     = (state_q == CLEAR);
    clr_done = (state_q == CLEAR) && (idx_q == LAST_IDX);
    clr_idx  = idx_q;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile_sb                                                  |
// | Purpose: 1W/2R register file with write-to-read bypass, a per-       |
// |          register pending (scoreboard) bit and a sequential bulk     |
// |          clear.                                                      |
// | Ports  : clk, rst_n          - clock / async active-low reset        |
// |          we, waddr, wdata    - write port                            |
// |          raddr1/2            - read addresses                        |
// |          rdata1/2, rvalid1/2 - combinational read data / not-pending |
// |          rsv_en, rsv_addr    - reserve (mark pending) request        |
// |          clr_req             - bulk clear request                    |
// |          busy, clr_done      - clear in progress / final clear cycle |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rvalid1,
  output logic              rvalid2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_ok;
  logic              rsv_ok;

  regfile_clr_ctl #(
    .ADDR_W (ADDR_W)
  ) u_clr_ctl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .clr_idx  (clr_idx)
  );

  // Writes and reserves are only honoured in IDLE and never target the
  // hardwired zero register.
  assign wr_ok  = we     && !busy && !((ZERO_REG != 0) && (waddr    == '0));
  assign rsv_ok = rsv_en && !busy && !((ZERO_REG != 0) && (rsv_addr == '0));

  // A clear that coincides with clr_req's IDLE cycle is not yet busy, so the
  // same-cycle write lands first and the clear overwrites it later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (busy) begin
      regs_q[clr_idx] <= '0;
    end else if (wr_ok) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Reserve is applied after the write-clear so it wins on an address tie.
  always_comb begin
    pend_d = pend_q;
    if (busy) begin
      pend_d[clr_idx] = 1'b0;
    end else begin
      if (wr_ok)  pend_d[waddr]    = 1'b0;
      if (rsv_ok) pend_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // Read ports. Reset is gated in explicitly so a write presented during
  // reset cannot leak through the bypass path.
  always_comb begin
    rdata1  = regs_q[raddr1];
    rvalid1 = ~pend_q[raddr1];
    if (!rst_n) begin
      rdata1  = '0;
      rvalid1 = 1'b1;
    end else if (busy) begin
      rdata1  = '0;
      rvalid1 = 1'b0;
    end else if (wr_ok && (waddr == raddr1)) begin
      rdata1  = wdata;
      rvalid1 = 1'b1;
    end
  end

  always_comb begin
    rdata2  = regs_q[raddr2];
    rvalid2 = ~pend_q[raddr2];
    if (!rst_n) begin
      rdata2  = '0;
      rvalid2 = 1'b1;
    end else if (busy) begin
      rdata2  = '0;
      rvalid2 = 1'b0;
    end else if (wr_ok && (waddr == raddr2)) begin
      rdata2  = wdata;
      rvalid2 = 1'b1;
    end
  end

endmodule
`default_nettype wire
